// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the multicycle multiply/divide unit.
//   state_t       - FSM state encoding (IDLE, MULT, DIV, FIN, DZ)
//   WIDTH_DEFAULT - default operand/result width
//   cnt_width()   - iteration counter width for a given operand width
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        DZ   = 3'd4
    } state_t;

    localparam int WIDTH_DEFAULT = 32;

    // One extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(WIDTH_DEFAULT);

endpackage

// File: rtl/mult_div_unit_div_step.sv
// restoring_div_step: one combinational iteration of unsigned restoring division.
//   rem, quot   in  - partial remainder and dividend/quotient shift register
//   divisor     in  - divisor magnitude (non-zero)
//   rem_next    out - partial remainder after the trial subtract
//   quot_next   out - shift register with the new quotient bit in the LSB
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor always holds, so the trial difference lies in
    // [-divisor, divisor) and its MSB is a reliable borrow flag.
    always_comb begin
        shifted = {rem, quot[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = shifted[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply (radix-2 Booth) and divide
// (restoring on magnitudes) responder, one iteration per clock.
//   clk, reset           - clock, synchronous active-high reset
//   mult_start/div_start - one-cycle requests, accepted only in IDLE
//   a, b                 - operands, sampled with the accepted request
//   hi_out/lo_out        - mult: {upper, lower} product; div: {remainder, quotient}
//   busy                 - high while iterating
//   done                 - one-cycle pulse, results valid from this cycle
//   divby0               - one-cycle pulse, divisor was zero
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             divby0
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state;
    logic [CNT_W-1:0]   cnt;

    // Mult: {acc_hi, acc_lo, acc_q} is the 2*WIDTH+1-bit Booth accumulator,
    // opnd is the multiplicand. Div: acc_hi is the partial remainder, acc_lo
    // the dividend/quotient shift register, opnd the divisor magnitude.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               acc_q;
    logic [WIDTH-1:0]   opnd;
    logic               neg_q;
    logic               neg_r;

    logic signed [WIDTH:0] hi_ext;
    logic signed [WIDTH:0] a_ext;
    logic signed [WIDTH:0] booth_sum;

    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        cond_neg = neg ? (~v + 1'b1) : v;
    endfunction

    // Magnitude of the most-negative value is 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        mag = cond_neg(v, v[WIDTH-1]);
    endfunction

    // Booth add/subtract is done one bit wider than the upper half so that
    // subtracting the most-negative multiplicand cannot overflow; the shift
    // then folds that extra bit back into the accumulator.
    always_comb begin
        hi_ext    = {acc_hi[WIDTH-1], acc_hi};
        a_ext     = {opnd[WIDTH-1], opnd};
        booth_sum = hi_ext;
        case ({acc_lo[0], acc_q})
            2'b01:   booth_sum = hi_ext + a_ext;
            2'b10:   booth_sum = hi_ext - a_ext;
            default: booth_sum = hi_ext;
        endcase
    end

    restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem       (acc_hi),
        .quot      (acc_lo),
        .divisor   (opnd),
        .rem_next  (rem_next),
        .quot_next (quot_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi_out <= '0;
            lo_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Multiply wins when both requests arrive together.
                    if (mult_start) begin
                        state  <= MULT;
                        cnt    <= '0;
                        acc_hi <= '0;
                        acc_lo <= b;
                        acc_q  <= 1'b0;
                        opnd   <= a;
                    end else if (div_start) begin
                        if (b == '0) begin
                            state <= DZ;
                        end else begin
                            state  <= DIV;
                            cnt    <= '0;
                            acc_hi <= '0;
                            acc_lo <= mag(a);
                            opnd   <= mag(b);
                            neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_r  <= a[WIDTH-1];
                        end
                    end
                end
                MULT: begin
                    acc_hi <= booth_sum[WIDTH:1];
                    acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
                    acc_q  <= acc_lo[0];
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        hi_out <= booth_sum[WIDTH:1];
                        lo_out <= {booth_sum[0], acc_lo[WIDTH-1:1]};
                        state  <= FIN;
                    end
                end
                DIV: begin
                    acc_hi <= rem_next;
                    acc_lo <= quot_next;
                    cnt    <= cnt + 1'b1;
                    // Sign fix-up folded into the last iteration: quotient
                    // truncates toward zero, remainder follows the dividend.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        hi_out <= cond_neg(rem_next, neg_r);
                        lo_out <= cond_neg(quot_next, neg_q);
                        state  <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                DZ:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == MULT) || (state == DIV);
    assign done   = (state == FIN);
    assign divby0 = (state == DZ);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mult_start = 1'b0;
    logic          div_start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  hi_out, lo_out;
    logic          busy, done, divby0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .a          (a),
        .b          (b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .busy       (busy),
        .done       (done),
        .divby0     (divby0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit           is_dz;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           c0;
    } exp_t;

    exp_t         sb[$];
    int           checks = 0;
    int           failures = 0;
    int           done_count = 0;
    int           busy_run = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        exp_t e;
        if (done || divby0) begin
            chk("done_divby0_exclusive", 64'(done && divby0), 64'd0);
            chk("resp_while_busy", 64'(busy), 64'd0);
            if (done) done_count++;
            if (sb.size() == 0) begin
                chk("unexpected_response", 64'(done), 64'(divby0 && 1'b0) + 64'd2);
            end else begin
                e = sb.pop_front();
                chk("resp_kind_divby0", 64'(divby0), 64'(e.is_dz));
                chk("hi_out", 64'(hi_out), 64'(e.hi));
                chk("lo_out", 64'(lo_out), 64'(e.lo));
                chk("latency", 64'(cyc - e.c0), e.is_dz ? 64'd1 : 64'(W + 1));
                if (done) chk("busy_cycles", 64'(busy_run), 64'(W));
            end
        end
        if (busy) busy_run++;
        else busy_run = 0;
    end

    // Reference model: plain 64-bit signed arithmetic.
    task automatic issue(input bit is_div, input bit both, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t   e;
        longint sa, sbv, p, q, r;
        sa  = longint'($signed(av));
        sbv = longint'($signed(bv));
        @(negedge clk);
        e.is_dz = 1'b0;
        if (!is_div || both) begin
            p    = sa * sbv;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (bv == '0) begin
            e.is_dz = 1'b1;
            e.hi    = mdl_hi;
            e.lo    = mdl_lo;
        end else begin
            q    = sa / sbv;
            r    = sa % sbv;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        mdl_hi = e.hi;
        mdl_lo = e.lo;
        e.c0 = cyc;
        sb.push_back(e);
        mult_start = !is_div || both;
        div_start  = is_div || both;
        a = av;
        b = bv;
        @(posedge clk);
        @(negedge clk);
        mult_start = 1'b0;
        div_start  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("response_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corner[5];
        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    initial begin
        int dc0;
        logic [W-1:0] ra, rb;
        bit rdiv;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_divby0", 64'(divby0), 64'd0);
        chk("reset_hi", 64'(hi_out), 64'd0);
        chk("reset_lo", 64'(lo_out), 64'd0);

        // Reset in the middle of a multiply
        issue(1'b0, 1'b0, 32'd123, 32'd456);
        repeat (9) @(negedge clk);
        sb.delete();
        mdl_hi = '0;
        mdl_lo = '0;
        dc0 = done_count;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midop_reset_busy", 64'(busy), 64'd0);
        chk("midop_reset_hi", 64'(hi_out), 64'd0);
        chk("midop_reset_lo", 64'(lo_out), 64'd0);
        repeat (50) @(negedge clk);
        chk("midop_reset_no_done", 64'(done_count - dc0), 64'd0);

        // Directed operations
        issue(1'b0, 1'b0, 32'd7, 32'hFFFF_FFFD);             wait_idle();
        issue(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);     wait_idle();
        issue(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2);             wait_idle();
        issue(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);     wait_idle();
        issue(1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF);     wait_idle();

        // Divide by zero with hi_out=0x1234 held, then a multiply two edges later
        issue(1'b1, 1'b0, 32'h1234, 32'h1_0000);             wait_idle();
        dc0 = done_count;
        issue(1'b1, 1'b0, 32'd99, 32'd0);
        issue(1'b0, 1'b0, 32'd11, 32'hFFFF_FFF0);
        wait_idle();
        chk("dz_then_mult_done_count", 64'(done_count - dc0), 64'd1);

        // Contention: both starts, then a div_start while busy
        dc0 = done_count;
        issue(1'b1, 1'b1, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        div_start = 1'b1;
        a = 32'd100;
        b = 32'd7;
        @(negedge clk);
        div_start = 1'b0;
        wait_idle();
        repeat (50) @(negedge clk);
        chk("contention_single_done", 64'(done_count - dc0), 64'd1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            ra = pick();
            rb = pick();
            if (rdiv && $urandom_range(0, 9) == 0) rb = '0;
            issue(rdiv, 1'b0, ra, rb);
            wait_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multicycle signed multiply/divide responder for the MIPS-style datapath. The control unit issues a start request. This block iterates and returns HI/LO results with a done pulse, or signals division by zero. The control unit then holds its FSM waiting on done/divby0 and gates hiwrite/lowrite from them.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
mult_start  in  1  one-cycle request: signed multiply a*b
div_start  in  1  one-cycle request: signed divide a/b
a  in  WIDTH  operand A (multiplicand / dividend), sampled on start
b  in  WIDTH  operand B (multiplier / divisor), sampled on start
hi_out  out  WIDTH  mult: upper product half; div: remainder
lo_out  out  WIDTH  mult: lower product half; div: quotient
busy  out  1  high while iterating
done  out  1  one-cycle pulse, hi_out/lo_out valid from this cycle
divby0  out  1  one-cycle pulse, divisor was zero

Behaviour:
- Reset (synchronous, active-high): state=IDLE; hi_out=0, lo_out=0, busy=0, done=0, divby0=0; iteration counter=0.
- Reset mid-operation aborts the operation; all outputs return to reset values on the next edge.
- States and transitions:
  - IDLE: on mult_start -> MULT; on div_start with b!=0 -> DIV; on div_start with b==0 -> DZ.
  - MULT/DIV: counter runs 0..WIDTH-1; -> FIN after the last iteration.
  - FIN: -> IDLE (one cycle).
  - DZ: -> IDLE (one cycle).
- Start timing: a, b and the start request are sampled at edge k in IDLE only. Starts while busy=1 or in FIN/DZ are ignored.
- Simultaneous mult_start and div_start: multiply wins; div_start is dropped.
- Latency: busy=1 for cycles k+1..k+WIDTH. In FIN (cycle k+WIDTH+1), done=1, busy=0, and hi_out/lo_out carry the result. Results are held until the next accepted start or reset.
- Multiply: radix-2 Booth on a 2*WIDTH+1-bit accumulator, one bit per cycle, arithmetic right shift. {hi_out,lo_out} is the exact 2*WIDTH-bit two's-complement product.
- Divide: restoring division on operand magnitudes, then sign fix-up in the final iteration.
  - Quotient truncates toward zero.
  - Remainder sign equals dividend sign, with |rem| < |b|.
  - Most-negative / -1: lo_out=0x80000000, hi_out=0. No exception.
- Divide by zero: in DZ (cycle k+1), divby0=1, done stays 0, hi_out/lo_out unchanged, no iterations performed.
- hi_out/lo_out update only on entry to FIN. Intermediate accumulator values are never visible on the outputs.
- done and divby0 are mutually exclusive and never high while busy=1.

Decomposition:
- Package mult_div_pkg:
  - typedef enum state_t {IDLE, MULT, DIV, FIN, DZ}
  - localparam WIDTH_DEFAULT=32
  - counter width constant $clog2(WIDTH)+1
- One sub-module is natural: restoring_div_step, a combinational single-iteration trial subtract/shift on {rem, quot}, instantiated once.
- The Booth step stays inline in the FSM.

Test Plan:
- Reset mid-op: mult_start, then reset at iteration 10 -> next cycle busy=0, hi_out=lo_out=0, state IDLE; no done pulse afterwards.
- mult_start, a=7, b=-3 -> busy for cycles k+1..k+32; done at k+33; hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB.
- mult_start, a=0x80000000, b=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000.
- div_start, a=-7, b=2 -> done at k+33; lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). Then a=0x80000000, b=-1 -> lo_out=0x80000000, hi_out=0.
- div_start, b=0, with hi_out=0x1234 from a prior op -> divby0 pulse at k+1, done never asserted, hi_out still 0x1234; mult_start at k+2 is accepted.
- Contention: mult_start and div_start together (a=5, b=6) -> lo_out=30, hi_out=0. A div_start issued while busy is ignored; exactly one done pulse occurs.
